// File: rtl/fb_stream_pkg.sv
// Shared types and constants for the frame-buffer read scheduler.
package fb_stream_pkg;

   localparam int unsigned FIFO_DEPTH = 2;
   localparam int unsigned PIX_W_DEF  = 12;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

   typedef struct packed {
      logic                 sop;
      logic                 eop;
      logic [PIX_W_DEF-1:0] data;
   } fifo_entry_t;

endpackage

// File: rtl/fb_skid_fifo.sv
// Two-entry skid FIFO; entry 0 is always the head and drives the output directly.
module fb_skid_fifo
   import fb_stream_pkg::*;
#(
   parameter int unsigned PIX_W = PIX_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             push_sop,
   input  logic             push_eop,
   input  logic [PIX_W-1:0] push_data,
   input  logic             pop,
   output logic             head_sop,
   output logic             head_eop,
   output logic [PIX_W-1:0] head_data,
   output logic [1:0]       count
);

   typedef struct packed {
      logic             sop;
      logic             eop;
      logic [PIX_W-1:0] data;
   } entry_t;

   entry_t     mem_q [FIFO_DEPTH];
   entry_t     mem_d [FIFO_DEPTH];
   logic [1:0] count_q, count_d;
   logic [1:0] level;
   logic       pop_ok;

   // Entries shift toward the head on pop; a push lands just past the surviving entries.
   always_comb begin
      pop_ok  = pop && (count_q != '0);
      level   = count_q - {1'b0, pop_ok};
      mem_d   = mem_q;
      if (pop_ok) begin
         mem_d[0] = mem_q[1];
      end
      if (push) begin
         if (level == 2'd0) begin
            mem_d[0] = '{sop: push_sop, eop: push_eop, data: push_data};
         end else begin
            mem_d[1] = '{sop: push_sop, eop: push_eop, data: push_data};
         end
      end
      count_d = level + {1'b0, push};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         assert (!(push && level == 2'(FIFO_DEPTH)));
         count_q <= count_d;
         mem_q   <= mem_d;
      end
   end

   assign head_sop  = mem_q[0].sop;
   assign head_eop  = mem_q[0].eop;
   assign head_data = mem_q[0].data;
   assign count     = count_q;

endmodule

// File: rtl/fb_stream_sched.sv
// Raster-order frame-buffer reader emitting one Avalon-ST packet per frame.
module fb_stream_sched
   import fb_stream_pkg::*;
#(
   parameter int unsigned WIDTH  = 320,
   parameter int unsigned HEIGHT = 240,
   parameter int unsigned ADDR_W = 17,
   parameter int unsigned PIX_W  = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [PIX_W-1:0]  rd_data,
   output logic [PIX_W-1:0]  src_data,
   output logic              src_valid,
   input  logic              src_ready,
   output logic              src_sop,
   output logic              src_eop,
   output logic              busy,
   output logic              frame_done
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              inflight_q, inflight_d;
   logic              infl_sop_q, infl_sop_d;
   logic              infl_eop_q, infl_eop_d;
   logic              frame_done_q, frame_done_d;

   logic [1:0] fifo_count;
   logic [2:0] occupancy;
   logic       pop;
   logic       issue;

   assign src_valid = (fifo_count != '0);
   assign pop       = src_valid && src_ready;

   // Issue only if the FIFO can still absorb everything already requested.
   always_comb begin
      occupancy = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};
      issue     = (state_q == RUN) && (occupancy < 3'd2);
   end

   always_comb begin
      state_d      = state_q;
      rd_addr_d    = rd_addr_q;
      inflight_d   = issue;
      infl_sop_d   = (rd_addr_q == '0);
      infl_eop_d   = (rd_addr_q == LAST_ADDR);
      frame_done_d = pop && src_eop;
      unique case (state_q)
         IDLE: begin
            if (enable) begin
               state_d   = RUN;
               rd_addr_d = '0;
            end
         end
         RUN: begin
            if (issue) begin
               if (rd_addr_q == LAST_ADDR) begin
                  rd_addr_d = '0;
                  if (!enable) begin
                     state_d = DRAIN;
                  end
               end else begin
                  rd_addr_d = rd_addr_q + ADDR_W'(1);
               end
            end
         end
         DRAIN: begin
            if (!inflight_q && fifo_count == '0) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         rd_addr_q    <= '0;
         inflight_q   <= 1'b0;
         infl_sop_q   <= 1'b0;
         infl_eop_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         rd_addr_q    <= rd_addr_d;
         inflight_q   <= inflight_d;
         infl_sop_q   <= infl_sop_d;
         infl_eop_q   <= infl_eop_d;
         frame_done_q <= frame_done_d;
      end
   end

   fb_skid_fifo #(
      .PIX_W(PIX_W)
   ) u_fifo (
      .clk      (clk),
      .rst      (reset),
      .push     (inflight_q),
      .push_sop (infl_sop_q),
      .push_eop (infl_eop_q),
      .push_data(rd_data),
      .pop      (pop),
      .head_sop (src_sop),
      .head_eop (src_eop),
      .head_data(src_data),
      .count    (fifo_count)
   );

   assign rd_en      = issue;
   assign rd_addr    = rd_addr_q;
   assign busy       = (state_q != IDLE);
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fb_stream_sched.sv
// Scoreboard bench for fb_stream_sched on a 4x2 frame with a random-content frame buffer.
module tb_fb_stream_sched;

   localparam int unsigned W    = 4;
   localparam int unsigned H    = 2;
   localparam int unsigned NPIX = W * H;
   localparam int unsigned AW   = 3;
   localparam int unsigned PW   = 12;

   logic          clk = 1'b0;
   logic          reset, enable, src_ready;
   logic          rd_en, src_valid, src_sop, src_eop, busy, frame_done;
   logic [AW-1:0] rd_addr;
   logic [PW-1:0] rd_data, src_data;

   typedef struct packed {
      logic          sop;
      logic          eop;
      logic [PW-1:0] data;
   } beat_t;

   logic [PW-1:0] fb_mem [NPIX];
   beat_t         exp_q [$];
   beat_t         prev_beat, b;
   logic          prev_stall, prev_eop_acc;
   int unsigned   checks = 0, failures = 0;
   int unsigned   issued = 0, accepted = 0, done_pulses = 0, cyc_cnt = 0;

   always #5 clk = ~clk;

   fb_stream_sched #(
      .WIDTH (W),
      .HEIGHT(H),
      .ADDR_W(AW),
      .PIX_W (PW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .src_data  (src_data),
      .src_valid (src_valid),
      .src_ready (src_ready),
      .src_sop   (src_sop),
      .src_eop   (src_eop),
      .busy      (busy),
      .frame_done(frame_done)
   );

   // Frame buffer: registered read, one cycle of latency.
   always @(posedge clk) rd_data <= fb_mem[rd_addr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_frame();
      for (int unsigned i = 0; i < NPIX; i++) begin
         exp_q.push_back('{sop: (i == 0), eop: (i == NPIX - 1), data: fb_mem[i]});
      end
   endtask

   task automatic wait_idle(input int unsigned bound, input bit rnd);
      int unsigned n = 0;
      while ((busy || exp_q.size() != 0) && n < bound) begin
         if (rnd) src_ready = 1'($urandom_range(0, 1));
         cyc();
         n++;
      end
      chk("idle_timeout", 32'(n < bound), 32'd1);
      src_ready = 1'b1;
      cyc();
      cyc();
   endtask

   task automatic latency_check();
      push_frame();
      enable = 1'b1;
      cyc();
      enable = 1'b0;
      chk("lat_e1_rd_en", 32'(rd_en), 32'd1);
      chk("lat_e1_addr", 32'(rd_addr), 32'd0);
      cyc();
      chk("lat_e2_valid", 32'(src_valid), 32'd0);
      cyc();
      chk("lat_e3_valid", 32'(src_valid), 32'd1);
      chk("lat_e3_sop", 32'(src_sop), 32'd1);
      chk("lat_e3_data", 32'(src_data), 32'(fb_mem[0]));
   endtask

   task automatic wait_addr(input int unsigned a);
      int unsigned n = 0;
      while (!(rd_en && rd_addr == AW'(a)) && n < 100) begin
         cyc();
         n++;
      end
      chk("wait_addr_timeout", 32'(n < 100), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_rd_en"}, 32'(rd_en), 32'd0);
      chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
      chk({tag, "_src_valid"}, 32'(src_valid), 32'd0);
      chk({tag, "_src_sop"}, 32'(src_sop), 32'd0);
      chk({tag, "_src_eop"}, 32'(src_eop), 32'd0);
      chk({tag, "_src_data"}, 32'(src_data), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
   endtask

   // Monitor: compares accepted beats against the scoreboard and tracks stream invariants.
   always @(negedge clk) begin
      cyc_cnt++;
      if (reset) begin
         issued       = 0;
         accepted     = 0;
         prev_stall   = 1'b0;
         prev_eop_acc = 1'b0;
      end else begin
         chk("frame_done", 32'(frame_done), 32'(prev_eop_acc));
         if (frame_done) done_pulses++;
         if (prev_stall) begin
            chk("hold_valid", 32'(src_valid), 32'd1);
            chk("hold_beat", 32'({src_sop, src_eop, src_data}), 32'(prev_beat));
         end
         if (rd_en) begin
            chk("rd_addr", 32'(rd_addr), issued % NPIX);
            issued++;
         end
         if (src_valid && src_ready) begin
            chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               b = exp_q.pop_front();
               chk("beat", 32'({src_sop, src_eop, src_data}), 32'(b));
            end
            accepted++;
         end
         chk("outstanding", 32'((issued - accepted) <= 2), 32'd1);
         prev_stall   = src_valid && !src_ready;
         prev_beat    = '{sop: src_sop, eop: src_eop, data: src_data};
         prev_eop_acc = src_valid && src_ready && src_eop;
      end
   end

   initial begin
      int unsigned i0, d0, a0, t1, t24, n;
      for (int unsigned i = 0; i < NPIX; i++) fb_mem[i] = PW'($urandom);
      reset     = 1'b1;
      enable    = 1'b0;
      src_ready = 1'b1;
      cyc();
      cyc();
      check_reset_outputs("rst");
      reset = 1'b0;
      cyc();

      // Single frame, enable pulsed, sink always ready.
      i0 = issued;
      d0 = done_pulses;
      latency_check();
      wait_idle(100, 1'b0);
      chk("A_reads", issued - i0, 32'd8);
      chk("A_busy", 32'(busy), 32'd0);
      chk("A_done", done_pulses - d0, 32'd1);

      // Three back-to-back frames, no gap between them.
      i0 = issued;
      d0 = done_pulses;
      a0 = accepted;
      repeat (3) push_frame();
      enable = 1'b1;
      n = 0;
      while (accepted - a0 < 1 && n < 200) begin cyc(); n++; end
      t1 = cyc_cnt;
      while (accepted - a0 < 16 && n < 200) begin cyc(); n++; end
      enable = 1'b0;
      while (accepted - a0 < 24 && n < 200) begin cyc(); n++; end
      t24 = cyc_cnt;
      chk("B_timeout", 32'(n < 200), 32'd1);
      chk("B_gapless", t24 - t1, 32'd23);
      wait_idle(100, 1'b0);
      chk("B_reads", issued - i0, 32'd24);
      chk("B_done", done_pulses - d0, 32'd3);

      // Random backpressure, one frame at a time.
      repeat (3) begin
         i0 = issued;
         push_frame();
         src_ready = 1'($urandom_range(0, 1));
         enable = 1'b1;
         cyc();
         enable = 1'b0;
         wait_idle(400, 1'b1);
         chk("C_reads", issued - i0, 32'd8);
      end

      // Enable dropped mid-frame: frame completes, nothing reissued.
      i0 = issued;
      d0 = done_pulses;
      push_frame();
      enable = 1'b1;
      wait_addr(3);
      enable = 1'b0;
      wait_idle(100, 1'b0);
      cyc();
      cyc();
      chk("D_reads", issued - i0, 32'd8);
      chk("D_busy", 32'(busy), 32'd0);
      chk("D_done", done_pulses - d0, 32'd1);

      // Reset mid-frame with the sink stalled.
      push_frame();
      enable = 1'b1;
      wait_addr(5);
      src_ready = 1'b0;
      enable    = 1'b0;
      cyc();
      cyc();
      reset = 1'b1;
      #1;
      check_reset_outputs("E_rst");
      exp_q.delete();
      cyc();
      reset     = 1'b0;
      src_ready = 1'b1;
      cyc();
      latency_check();
      wait_idle(100, 1'b0);
      chk("E_reads", issued, 32'd8);

      // Sink stalled from the start: exactly two reads, pixel 0 held.
      src_ready = 1'b0;
      i0 = issued;
      push_frame();
      enable = 1'b1;
      cyc();
      enable = 1'b0;
      repeat (10) cyc();
      chk("F_reads_stalled", issued - i0, 32'd2);
      chk("F_valid", 32'(src_valid), 32'd1);
      chk("F_sop", 32'(src_sop), 32'd1);
      chk("F_data", 32'(src_data), 32'(fb_mem[0]));
      src_ready = 1'b1;
      wait_idle(100, 1'b0);
      chk("F_reads", issued - i0, 32'd8);

      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fb_stream_sched.md
# fb_stream_sched

Read-side scheduler for the camera frame buffer. Walks the buffer in raster order, issues one read per pixel, absorbs the buffer's one-cycle read latency in a two-entry skid FIFO, and emits each frame as one Avalon-ST video packet (SOP on pixel 0, EOP on last pixel) into the video scaler sink. Sits on the VGA-side clock, between the frame buffer read port and the scaler, and replaces free-running read-address counters.

## Interface
- WIDTH, 320, pixels per line
- HEIGHT, 240, lines per frame
- ADDR_W, 17, frame-buffer address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT
- PIX_W, 12, raw pixel width (RGB444)
- clk  in  1  VGA-side pixel clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- enable  in  1  level; request continuous streaming; sampled only in IDLE and at frame boundaries
- rd_en  out  1  read strobe to frame buffer (for bench accounting; buffer may ignore it)
- rd_addr  out  ADDR_W  read address, registered
- rd_data  in  PIX_W  frame-buffer data, valid exactly one cycle after the edge that latched rd_addr
- src_data  out  PIX_W  pixel to scaler
- src_valid  out  1  src_data valid
- src_ready  in  1  scaler accepts beat when src_valid & src_ready
- src_sop  out  1  beat is pixel 0
- src_eop  out  1  beat is pixel WIDTH*HEIGHT-1
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse, cycle after EOP beat accepted

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: no reads issued; enable=1 at an edge -> RUN with pixel counter = 0.
- RUN: rd_en = (fifo_count + inflight - pop) < 2, pop = src_valid & src_ready. On issue, counter increments; at WIDTH*HEIGHT-1 it wraps to 0. Issuing the last pixel with enable=0 -> DRAIN (no further issue); with enable=1 stay RUN, next issue is pixel 0 of next frame, no gap.
- DRAIN: no issue; when inflight=0 and fifo empty -> IDLE.
- inflight: 1-bit register, set on issue, cleared next cycle; that cycle rd_data is written to FIFO tagged sop=(addr==0), eop=(addr==last).
- FIFO: 2 entries of {sop, eop, data}; head drives src_*; src_valid = fifo_count != 0. Never overflows by construction; overflow is an assertion failure.
- Output holds stable (data, sop, eop) while src_valid & !src_ready.
- Address arithmetic: plain increment/compare against WIDTH*HEIGHT-1, no multiplier.

## Timing
- Reset values: rd_en 0, rd_addr 0, src_valid 0, src_sop 0, src_eop 0, src_data 0, busy 0, frame_done 0, state IDLE, FIFO empty, inflight 0.
- Latency: enable sampled at edge E1 -> rd_en=1, rd_addr=0 after E1 -> rd_data=pix0 after E2 -> src_valid=1, src_sop=1 after E3.
- Throughput: with src_ready held 1, one beat per cycle sustained, including across frame boundaries.
- src_ready low: at most 2 further reads complete; issue stalls until space.
- enable falling mid-frame: current frame completes fully; enable rising in DRAIN ignored until IDLE.
- Reset asserted mid-frame: all outputs to reset values immediately; stream restarts at pixel 0 with SOP after release.
- Simultaneous push and pop with count 2: legal, count stays 2.

## Structure
- Package fb_stream_pkg: state enum type (IDLE/RUN/DRAIN), FIFO entry struct {sop, eop, data} parameterised via PIX_W default, FIFO_DEPTH=2.
- One sub-module: fb_skid_fifo (2-entry, push/pop/count, registered head).

## Test plan
- WIDTH=4, HEIGHT=2, src_ready=1, enable pulsed 1 cycle: rd_addr 0..7 once, 8 beats with data=addr pattern, sop on beat 0, eop on beat 7, frame_done one cycle later, busy=0 after.
- Default size, enable=1, src_ready=1 for 3 frames: 230400 beats with no idle cycle, sop every 76800 beats, 3 frame_done pulses.
- WIDTH=4, HEIGHT=2, src_ready random 50%: beat order 0..7 intact, held output unchanged while stalled, FIFO count never exceeds 2.
- enable dropped at pixel 3 of 8: frame completes to pixel 7 with eop, then IDLE; no pixel 0 reissued.
- Reset asserted at pixel 5 with src_ready=0: all outputs 0 same cycle; after release and enable=1, first beat is pixel 0 with sop=1 at 3 edges.
- src_ready=0 from start: exactly 2 reads issued, src_valid=1 with pixel 0 held; release -> pixels 0,1,2... contiguous.
